ext_sram_ctrl: RTL

//  Parametrised external SRAM controller behind the CPU dispatcher. Claims bus requests addressed at or

---
 rtl/ext_sram_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ext_sram_ctrl.sv
// ============================================================================
// Module  : ext_sram_ctrl
// Brief   : External asynchronous SRAM controller with programmable
//           setup / access / hold / turnaround wait states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_sram_ctrl #(
    parameter int ADDR_SIZE          = 32,
    parameter int DATA_SIZE          = 32,
    parameter int EXT_ADDR_SIZE      = 20,
    parameter int INTERNAL_MEM_VALUE = 200,
    parameter int EXT_WINDOW_SIZE    = 2**20,
    parameter int SETUP_CYC          = 1,
    parameter int ACCESS_CYC         = 2,
    parameter int HOLD_CYC           = 1,
    parameter int TURN_CYC           = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_oe,
    input  logic                     rw_halt,
    input  logic                     read_q,
    input  logic                     write_q,
    input  logic [ADDR_SIZE-1:0]     addr_in,
    input  logic [DATA_SIZE-1:0]     data_in,
    output logic [DATA_SIZE-1:0]     data_out,
    output logic                     read_dn,
    output logic                     write_dn,
    output logic                     bad_addr,
    output logic                     busy,
    output logic [EXT_ADDR_SIZE-1:0] ext_mem_addr,
    output logic [DATA_SIZE-1:0]     ext_mem_data_o,
    input  logic [DATA_SIZE-1:0]     ext_mem_data_i,
    output logic                     ext_mem_data_oe,
    output logic                     prg_ce,
    output logic                     prg_oe,
    output logic                     prg_we
);

    // Wait counter sized for the longest programmed phase
    localparam int c_max_sa = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int c_max_ht = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int c_max_all = (c_max_sa > c_max_ht) ? c_max_sa : c_max_ht;
    localparam int c_cw = $clog2(c_max_all) + 1;

    localparam logic [c_cw-1:0] c_setup_ld  = c_cw'(SETUP_CYC - 1);
    localparam logic [c_cw-1:0] c_access_ld = c_cw'(ACCESS_CYC - 1);
    localparam logic [c_cw-1:0] c_hold_ld   = c_cw'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [c_cw-1:0] c_turn_ld   = c_cw'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    // Address window: [IMV, IMV + EXT_WINDOW_SIZE), end computed one bit wider
    localparam logic [ADDR_SIZE-1:0]     c_imv     = ADDR_SIZE'(INTERNAL_MEM_VALUE);
    localparam logic [ADDR_SIZE:0]       c_win_end = (ADDR_SIZE+1)'(INTERNAL_MEM_VALUE)
                                                   + (ADDR_SIZE+1)'(EXT_WINDOW_SIZE);
    localparam logic [EXT_ADDR_SIZE-1:0] c_imv_lo  = EXT_ADDR_SIZE'(INTERNAL_MEM_VALUE);

    localparam logic [3:0] c_idle      = 4'd0;
    localparam logic [3:0] c_rd_setup  = 4'd1;
    localparam logic [3:0] c_rd_access = 4'd2;
    localparam logic [3:0] c_rd_done   = 4'd3;
    localparam logic [3:0] c_wr_setup  = 4'd4;
    localparam logic [3:0] c_wr_pulse  = 4'd5;
    localparam logic [3:0] c_wr_hold   = 4'd6;
    localparam logic [3:0] c_wr_done   = 4'd7;
    localparam logic [3:0] c_bad_done  = 4'd8;
    localparam logic [3:0] c_turn      = 4'd9;

    localparam logic [3:0] c_after_done = (TURN_CYC > 0) ? c_turn : c_idle;
    localparam logic [3:0] c_after_wr   = (HOLD_CYC > 0) ? c_wr_hold : c_wr_done;

    logic [3:0]               r_state;
    logic [3:0]               w_next;
    logic [c_cw-1:0]          r_cnt;
    logic [c_cw-1:0]          w_load;
    logic [EXT_ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0]     r_wdata;
    logic [DATA_SIZE-1:0]     r_rdata;
    logic                     r_is_read;
    logic                     w_accept;
    logic                     w_out_of_win;
    logic [EXT_ADDR_SIZE-1:0] w_offset;

    // Only addresses at or above IMV belong to this controller
    assign w_accept     = (read_q | write_q) & (addr_in >= c_imv);
    assign w_out_of_win = ({1'b0, addr_in} >= c_win_end);
    // Low bits of (addr_in - IMV) equal the difference of the low bits
    assign w_offset     = addr_in[EXT_ADDR_SIZE-1:0] - c_imv_lo;

    // State register and wait counter; halt aborts regardless of clk_oe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
        end else if (rw_halt) begin
            r_state <= c_idle;
            r_cnt   <= '0;
        end else if (clk_oe) begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= w_load;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Next-state decode; phases end when the wait counter reaches zero
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    if (w_out_of_win)  w_next = c_bad_done;
                    else if (read_q)   w_next = c_rd_setup;
                    else               w_next = c_wr_setup;
                end
            end
            c_rd_setup:  if (r_cnt == '0) w_next = c_rd_access;
            c_rd_access: if (r_cnt == '0) w_next = c_rd_done;
            c_rd_done:   w_next = c_after_done;
            c_wr_setup:  if (r_cnt == '0) w_next = c_wr_pulse;
            c_wr_pulse:  if (r_cnt == '0) w_next = c_after_wr;
            c_wr_hold:   if (r_cnt == '0) w_next = c_wr_done;
            c_wr_done:   w_next = c_after_done;
            c_bad_done:  w_next = c_after_done;
            c_turn:      if (r_cnt == '0) w_next = c_idle;
            default:     w_next = c_idle;
        endcase
    end

    // Counter preload for the phase being entered
    always_comb begin
        w_load = '0;
        case (w_next)
            c_rd_setup, c_wr_setup:  w_load = c_setup_ld;
            c_rd_access, c_wr_pulse: w_load = c_access_ld;
            c_wr_hold:               w_load = c_hold_ld;
            c_turn:                  w_load = c_turn_ld;
            default:                 w_load = '0;
        endcase
    end

    // Request latch on accept and read-data capture on the last access cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_is_read <= 1'b0;
        end else if (clk_oe && !rw_halt) begin
            if (r_state == c_idle && w_accept) begin
                r_addr    <= w_offset;
                r_wdata   <= data_in;
                r_is_read <= read_q;
            end
            if (r_state == c_rd_access && r_cnt == '0) begin
                r_rdata <= ext_mem_data_i;
            end
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        prg_ce          = 1'b1;
        prg_oe          = 1'b1;
        prg_we          = 1'b1;
        ext_mem_data_oe = 1'b0;
        read_dn         = 1'b0;
        write_dn        = 1'b0;
        bad_addr        = 1'b0;
        data_out        = '0;
        case (r_state)
            c_rd_setup:  prg_ce = 1'b0;
            c_rd_access: begin
                prg_ce = 1'b0;
                prg_oe = 1'b0;
            end
            c_rd_done: begin
                read_dn  = 1'b1;
                data_out = r_rdata;
            end
            c_wr_setup: begin
                prg_ce          = 1'b0;
                ext_mem_data_oe = 1'b1;
            end
            c_wr_pulse: begin
                prg_ce          = 1'b0;
                prg_we          = 1'b0;
                ext_mem_data_oe = 1'b1;
            end
            c_wr_hold: begin
                prg_ce          = 1'b0;
                ext_mem_data_oe = 1'b1;
            end
            c_wr_done:   write_dn = 1'b1;
            c_bad_done: begin
                read_dn  = r_is_read;
                write_dn = ~r_is_read;
                bad_addr = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy           = (r_state != c_idle);
    assign ext_mem_addr   = r_addr;
    assign ext_mem_data_o = r_wdata;

endmodule

`default_nettype wire
